sdram_arbiter: RTL

- Two-client arbiter that sits directly upstream of the single-port SDRAM controller.
- Multiplexes a CPU-side client (port 0) and a video/DMA-side client (port 1) onto the controller's single toggle req/ack port.
- Every interface uses the same toggle handshake: a request is pending while req != ack.
- The block latches the granted request, forwards it, returns read data and completes the client handshake.

---
 rtl/sdram_arb_pkg.sv | 15 +
 rtl/sdram_arb_pick.sv | 31 +++
 rtl/sdram_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-client SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_e;

  typedef logic gnt_t;

  localparam int DW = 16;
  localparam int SW = 2;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner select for the SDRAM arbiter.
// SDRAM_ARB_RR_EN selects round-robin tie-break; otherwise fixed priority per PRIO.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int PRIO = 0
) (
  input  logic pend0_i,
  input  logic pend1_i,
`ifdef SDRAM_ARB_RR_EN
  input  gnt_t last_i,
`endif
  output logic any_o,
  output gnt_t win_o
);

  // A lone pending port always wins; only a tie depends on the build
  always_comb begin
    any_o = pend0_i | pend1_i;
    if (pend0_i && pend1_i) begin
`ifdef SDRAM_ARB_RR_EN
      win_o = ~last_i;
`else
      win_o = (PRIO != 0) ? 1'b1 : 1'b0;
`endif
    end else begin
      win_o = pend1_i;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client toggle-handshake arbiter in front of the single-port SDRAM controller.
// Define SDRAM_ARB_RR_EN for round-robin tie-break instead of fixed PRIO.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW   = 21,
  parameter int PRIO = 0
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          p0_req,
  output logic          p0_ack,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_a,
  input  logic [SW-1:0] p0_ds,
  input  logic [DW-1:0] p0_d,
  output logic [DW-1:0] p0_q,
  input  logic          p1_req,
  output logic          p1_ack,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_a,
  input  logic [SW-1:0] p1_ds,
  input  logic [DW-1:0] p1_d,
  output logic [DW-1:0] p1_q,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [SW-1:0] mem_ds,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  arb_state_e    state_q, state_d;
  gnt_t          gnt_q, gnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [SW-1:0] mem_ds_q, mem_ds_d;
  logic [DW-1:0] mem_d_q, mem_d_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic [DW-1:0] p0_rd_q, p0_rd_d;
  logic [DW-1:0] p1_rd_q, p1_rd_d;
  logic          any_s;
  gnt_t          win_s;

  sdram_arb_pick #(
    .PRIO (PRIO)
  ) u_pick (
    .pend0_i (p0_req ^ p0_ack_q),
    .pend1_i (p1_req ^ p1_ack_q),
`ifdef SDRAM_ARB_RR_EN
    .last_i  (gnt_q),
`endif
    .any_o   (any_s),
    .win_o   (win_s)
  );

  // Next-state and datapath selection for the SYNC/IDLE/BUSY sequence
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    mem_a_d   = mem_a_q;
    mem_ds_d  = mem_ds_q;
    mem_d_d   = mem_d_q;
    p0_ack_d  = p0_ack_q;
    p1_ack_d  = p1_ack_q;
    p0_rd_d   = p0_rd_q;
    p1_rd_d   = p1_rd_q;
    case (state_q)
      ST_SYNC: begin
        // Adopt whatever ack level the controller came out of reset with
        mem_req_d = mem_ack;
        state_d   = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_s) begin
          if (win_s) begin
            mem_we_d = p1_we;
            mem_a_d  = p1_a;
            mem_ds_d = p1_ds;
            mem_d_d  = p1_d;
          end else begin
            mem_we_d = p0_we;
            mem_a_d  = p0_a;
            mem_ds_d = p0_ds;
            mem_d_d  = p0_d;
          end
          mem_req_d = ~mem_req_q;
          gnt_d     = win_s;
          state_d   = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_req_q == mem_ack) begin
          if (gnt_q) begin
            p1_ack_d = p1_req;
            p1_rd_d  = mem_we_q ? p1_rd_q : mem_q;
          end else begin
            p0_ack_d = p0_req;
            p0_rd_d  = mem_we_q ? p0_rd_q : mem_q;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // State and output registers, cleared together with the controller
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= ST_SYNC;
      gnt_q     <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_a_q   <= {AW{1'b0}};
      mem_ds_q  <= {SW{1'b0}};
      mem_d_q   <= {DW{1'b0}};
      p0_ack_q  <= 1'b0;
      p1_ack_q  <= 1'b0;
      p0_rd_q   <= {DW{1'b0}};
      p1_rd_q   <= {DW{1'b0}};
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      mem_a_q   <= mem_a_d;
      mem_ds_q  <= mem_ds_d;
      mem_d_q   <= mem_d_d;
      p0_ack_q  <= p0_ack_d;
      p1_ack_q  <= p1_ack_d;
      p0_rd_q   <= p0_rd_d;
      p1_rd_q   <= p1_rd_d;
    end
  end

  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign mem_a   = mem_a_q;
  assign mem_ds  = mem_ds_q;
  assign mem_d   = mem_d_q;
  assign p0_ack  = p0_ack_q;
  assign p1_ack  = p1_ack_q;
  assign p0_q    = p0_rd_q;
  assign p1_q    = p1_rd_q;

endmodule
